// File: rtl/ac_lane_out_collector.sv
// Collects pixels from N_PARALLEL strip lanes and re-serialises them in raster order onto one AXI4-Stream master.
// Optional output handshake counter enabled by defining AC_OUT_HSKCNT_EN.
module ac_lane_out_collector #(
    parameter int N_PARALLEL         = 4,
    parameter int UPSP_WRTDATA_WIDTH = 24,
    parameter int AXISOUT_DATA_WIDTH = 24,
    parameter int DST_IMG_WIDTH      = 3840,
    parameter int DST_IMG_HEIGHT     = 2160,
    parameter int OUT_FIFO_DEPTH     = 8,
    parameter int CRF_DATA_WIDTH     = 32
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       crf_ac_UPSTART,
    input  logic                                       crf_ac_abort,
    input  logic [N_PARALLEL-1:0]                      upsp_ac_wvalid,
    input  logic [N_PARALLEL*UPSP_WRTDATA_WIDTH-1:0]   upsp_ac_wdata,
    output logic [N_PARALLEL-1:0]                      ac_upsp_wready,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic [AXISOUT_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic                                       m_axis_tlast,
    output logic                                       m_axis_user,
    output logic                                       ac_crf_processing,
    output logic                                       ac_crf_frame_done,
    output logic [CRF_DATA_WIDTH-1:0]                  ac_crf_OUTHSKCNT
);

    localparam int STRIP_W = DST_IMG_WIDTH / N_PARALLEL;
    localparam int COL_W   = (STRIP_W > 1) ? $clog2(STRIP_W) : 1;
    localparam int LANE_W  = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1;
    localparam int ROW_W   = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam int PTR_W   = $clog2(OUT_FIFO_DEPTH);
    localparam int W       = UPSP_WRTDATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [COL_W-1:0]  col;
    logic [LANE_W-1:0] lane;
    logic [ROW_W-1:0]  row;

    logic [N_PARALLEL-1:0] full, empty, push, pop;
    logic [W-1:0]          heads [N_PARALLEL];

    logic run_act;
    logic beat;
    logic last_col, last_lane, last_row;

    // Abort overrides any handshake in the cycle it is raised.
    assign run_act   = (state == S_RUN) && !crf_ac_abort;
    assign beat      = m_axis_tvalid && m_axis_tready;
    assign last_col  = (col  == COL_W'(STRIP_W - 1));
    assign last_lane = (lane == LANE_W'(N_PARALLEL - 1));
    assign last_row  = (row  == ROW_W'(DST_IMG_HEIGHT - 1));

    for (genvar g = 0; g < N_PARALLEL; g++) begin : g_lane
        logic [PTR_W:0] wr_ptr, rd_ptr;
        logic [W-1:0]   mem [OUT_FIFO_DEPTH];

        assign empty[g] = (wr_ptr == rd_ptr);
        assign full[g]  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                          (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        // Readiness comes from pre-pop occupancy, so a full FIFO never takes a push.
        assign push[g]  = run_act && upsp_ac_wvalid[g] && !full[g];
        assign pop[g]   = beat && (lane == LANE_W'(g));
        assign heads[g] = mem[rd_ptr[PTR_W-1:0]];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (crf_ac_abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) mem[wr_ptr[PTR_W-1:0]] <= upsp_ac_wdata[g*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (crf_ac_abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (crf_ac_UPSTART) state_nxt = S_RUN;
                S_RUN:   if (beat && last_col && last_lane && last_row) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ac_crf_processing = (state == S_RUN);
        ac_crf_frame_done = (state == S_DONE);
        ac_upsp_wready    = run_act ? ~full : '0;
        m_axis_tvalid     = run_act && !empty[lane];
    end

    // Flags and data are forced low without tvalid so nothing leaks from stale FIFO storage.
    assign m_axis_tdata = m_axis_tvalid ? heads[lane] : '0;
    assign m_axis_tlast = m_axis_tvalid && last_col && last_lane;
    assign m_axis_user  = m_axis_tvalid && (col == '0) && (lane == '0) && (row == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            lane <= '0;
            row  <= '0;
        end else if (crf_ac_abort || ((state == S_IDLE) && crf_ac_UPSTART)) begin
            col  <= '0;
            lane <= '0;
            row  <= '0;
        end else if (beat) begin
            if (last_col) begin
                col <= '0;
                if (last_lane) begin
                    lane <= '0;
                    row  <= last_row ? '0 : row + 1'b1;
                end else begin
                    lane <= lane + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

`ifdef AC_OUT_HSKCNT_EN
    logic [CRF_DATA_WIDTH-1:0] hsk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsk_cnt <= '0;
        end else if (crf_ac_abort || ((state == S_IDLE) && crf_ac_UPSTART)) begin
            hsk_cnt <= '0;
        end else if (beat) begin
            hsk_cnt <= hsk_cnt + 1'b1;
        end
    end

    assign ac_crf_OUTHSKCNT = hsk_cnt;
`else
    assign ac_crf_OUTHSKCNT = '0;
`endif

endmodule

// File: tb/tb_ac_lane_out_collector.sv
// Randomised bench for ac_lane_out_collector against a queue-based raster reference model.
module tb_ac_lane_out_collector;

    localparam int NP    = 2;
    localparam int DW    = 24;
    localparam int IMG_W = 8;
    localparam int IMG_H = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 32;
    localparam int STRIP = IMG_W / NP;
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int PER_LANE = STRIP * IMG_H;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               crf_ac_UPSTART = 1'b0;
    logic               crf_ac_abort = 1'b0;
    logic [NP-1:0]      upsp_ac_wvalid = '0;
    logic [NP*DW-1:0]   upsp_ac_wdata = '0;
    logic [NP-1:0]      ac_upsp_wready;
    logic               m_axis_tvalid;
    logic               m_axis_tready = 1'b0;
    logic [DW-1:0]      m_axis_tdata;
    logic               m_axis_tlast;
    logic               m_axis_user;
    logic               ac_crf_processing;
    logic               ac_crf_frame_done;
    logic [CW-1:0]      ac_crf_OUTHSKCNT;

    ac_lane_out_collector #(
        .N_PARALLEL(NP), .UPSP_WRTDATA_WIDTH(DW), .AXISOUT_DATA_WIDTH(DW),
        .DST_IMG_WIDTH(IMG_W), .DST_IMG_HEIGHT(IMG_H), .OUT_FIFO_DEPTH(DEPTH),
        .CRF_DATA_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .crf_ac_UPSTART(crf_ac_UPSTART), .crf_ac_abort(crf_ac_abort),
        .upsp_ac_wvalid(upsp_ac_wvalid), .upsp_ac_wdata(upsp_ac_wdata), .ac_upsp_wready(ac_upsp_wready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .m_axis_user(m_axis_user), .ac_crf_processing(ac_crf_processing),
        .ac_crf_frame_done(ac_crf_frame_done), .ac_crf_OUTHSKCNT(ac_crf_OUTHSKCNT)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: frame state, beat index and the contents of each lane FIFO.
    int            m_state = M_IDLE;
    int            mk = 0;
    int            mhsk = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] beat_log[$];
    logic [NP-1:0] acc;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_state = M_IDLE;
        mk = 0;
        mhsk = 0;
        q0.delete();
        q1.delete();
    endtask

    task automatic cyc(input logic [NP-1:0] wv, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic rdy, input logic st, input logic ab);
        logic          run_c, e_tv, e_last, e_user, e_beat;
        logic [NP-1:0] e_wr;
        logic [DW-1:0] e_data;
        int            e_lane;
        @(negedge clk);
        upsp_ac_wvalid = wv;
        upsp_ac_wdata  = {d1, d0};
        m_axis_tready  = rdy;
        crf_ac_UPSTART = st;
        crf_ac_abort   = ab;
        #1;
        run_c  = (m_state == M_RUN) && !ab;
        e_wr   = '0;
        e_wr[0] = run_c && (q0.size() < DEPTH);
        e_wr[1] = run_c && (q1.size() < DEPTH);
        e_lane = (mk / STRIP) % NP;
        e_tv   = run_c && ((e_lane == 0) ? (q0.size() > 0) : (q1.size() > 0));
        e_data = '0;
        if (e_tv) e_data = (e_lane == 0) ? q0[0] : q1[0];
        e_last = e_tv && ((mk % STRIP) == STRIP - 1) && (e_lane == NP - 1);
        e_user = e_tv && (mk == 0);
        chk_eq("wready", 32'(ac_upsp_wready), 32'(e_wr));
        chk_eq("tvalid", 32'(m_axis_tvalid), 32'(e_tv));
        chk_eq("tdata", 32'(m_axis_tdata), 32'(e_data));
        chk_eq("tlast", 32'(m_axis_tlast), 32'(e_last));
        chk_eq("user", 32'(m_axis_user), 32'(e_user));
        chk_eq("processing", 32'(ac_crf_processing), 32'(m_state == M_RUN));
        chk_eq("frame_done", 32'(ac_crf_frame_done), 32'(m_state == M_DONE));
`ifdef AC_OUT_HSKCNT_EN
        chk_eq("hskcnt", ac_crf_OUTHSKCNT, 32'(mhsk));
`else
        chk_eq("hskcnt", ac_crf_OUTHSKCNT, 32'd0);
`endif
        acc = wv & e_wr;
        e_beat = e_tv && rdy;
        if (ab) begin
            m_state = M_IDLE;
            mk = 0;
            mhsk = 0;
            q0.delete();
            q1.delete();
        end else if (m_state == M_IDLE) begin
            if (st) begin
                m_state = M_RUN;
                mk = 0;
                mhsk = 0;
            end
        end else if (m_state == M_DONE) begin
            m_state = M_IDLE;
        end else begin
            if (e_beat) begin
                beat_log.push_back(e_data);
                if (e_lane == 0) void'(q0.pop_front());
                else             void'(q1.pop_front());
                mk++;
                mhsk++;
                if (mk == TOTAL) m_state = M_DONE;
            end
            if (acc[0]) q0.push_back(d0);
            if (acc[1]) q1.push_back(d1);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cyc('0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        upsp_ac_wvalid = '0;
        m_axis_tready = 1'b0;
        crf_ac_UPSTART = 1'b0;
        crf_ac_abort = 1'b0;
        #1;
        chk_eq("rst_wready", 32'(ac_upsp_wready), 32'd0);
        chk_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk_eq("rst_user", 32'(m_axis_user), 32'd0);
        chk_eq("rst_processing", 32'(ac_crf_processing), 32'd0);
        chk_eq("rst_done", 32'(ac_crf_frame_done), 32'd0);
        chk_eq("rst_hskcnt", ac_crf_OUTHSKCNT, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_eq("post_rst_processing", 32'(ac_crf_processing), 32'd0);
    endtask

    // One frame: pv/pr = push/ready percentages, rdy_off = cycles of tready low,
    // l1_delay = cycles before lane1 starts, abort_at/rst_at = beat index to interrupt (-1 none).
    task automatic run_frame(input int pv, input int pr, input int rdy_off, input int l1_delay,
                             input int abort_at, input int rst_at, input int base0, input int base1,
                             input bit rnd);
        int            sent0, sent1;
        bit            ended;
        logic [NP-1:0] wv;
        logic [DW-1:0] d0, d1;
        logic          rdy, st, ab;
        sent0 = 0;
        sent1 = 0;
        ended = 0;
        beat_log.delete();
        for (int c = 0; c < 400; c++) begin
            if (c > 0 && m_state == M_IDLE) begin
                ended = 1;
                break;
            end
            if (rst_at >= 0 && m_state == M_RUN && mk == rst_at) begin
                do_reset();
                ended = 1;
                break;
            end
            wv[0] = (c > 0) && (sent0 < PER_LANE) && ($urandom_range(99) < 32'(pv));
            wv[1] = (c > l1_delay) && (sent1 < PER_LANE) && ($urandom_range(99) < 32'(pv));
            d0 = (base0 < 0) ? DW'($urandom) : DW'(base0 + sent0);
            d1 = (base1 < 0) ? DW'($urandom) : DW'(base1 + sent1);
            rdy = (c > rdy_off) && ($urandom_range(99) < 32'(pr));
            st = (c == 0) || (rnd && $urandom_range(9) == 0);
            ab = (abort_at >= 0) && (m_state == M_RUN) && (mk == abort_at);
            cyc(wv, d0, d1, rdy, st, ab);
            if (acc[0]) sent0++;
            if (acc[1]) sent1++;
        end
        if (!ended) chk_eq("frame_timeout_state", 32'(m_state), 32'(M_IDLE));
    endtask

    initial begin
        int exp_px;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        chk_eq("init_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk_eq("init_wready", 32'(ac_upsp_wready), 32'd0);
        chk_eq("init_tdata", 32'(m_axis_tdata), 32'd0);
        chk_eq("init_processing", 32'(ac_crf_processing), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Raster order with known pixel values
        run_frame(100, 100, 0, 0, -1, -1, 'h10, 'h20, 1'b0);
        chk_eq("raster_beats", 32'(beat_log.size()), 32'(TOTAL));
        for (int k = 0; k < TOTAL; k++) begin
            exp_px = (((k / STRIP) % NP) == 0 ? 'h10 : 'h20) + (k / IMG_W) * STRIP + (k % STRIP);
            if (k < beat_log.size()) chk_eq($sformatf("raster_px%0d", k), 32'(beat_log[k]), 32'(exp_px));
        end
        idle_cycles(3);
`ifdef AC_OUT_HSKCNT_EN
        chk_eq("hsk_after_frame", ac_crf_OUTHSKCNT, 32'(TOTAL));
`endif

        // Backpressure, lane starvation, abort and restart, mid-frame reset
        run_frame(100, 100, 5, 0, -1, -1, 'h10, 'h20, 1'b0);
        idle_cycles(1);
        run_frame(100, 100, 0, 20, -1, -1, 'h10, 'h20, 1'b0);
        idle_cycles(1);
        run_frame(100, 100, 0, 0, 6, -1, 'h10, 'h20, 1'b0);
        idle_cycles(2);
        run_frame(100, 100, 0, 0, -1, -1, 'h10, 'h20, 1'b0);
        chk_eq("restart_first_px", 32'(beat_log.size() > 0 ? beat_log[0] : '0), 32'h10);
        run_frame(100, 100, 0, 0, -1, 3, 'h10, 'h20, 1'b0);
        idle_cycles(2);

        // Randomised traffic, data and stray start pulses
        repeat (6) begin
            run_frame(60, 70, 0, 0, -1, -1, -1, -1, 1'b1);
            idle_cycles($urandom_range(3));
        end
        run_frame(80, 50, 0, 0, 9, -1, -1, -1, 1'b1);
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ac_lane_out_collector.md
Name: ac_lane_out_collector

Overview:
- Parametrised successor to the single-path output side of access control.
- Collects upsampled pixels from N_PARALLEL upsampler lanes, each owning a vertical strip of the destination image. Each lane has its own output FIFO.
- Re-serialises the pixels in raster order onto one AXI4-Stream master, with frame-start (tuser), end-of-line (tlast), a frame-done pulse and status toward the config register file.

Parameters:
- N_PARALLEL, 4, number of upsampler lanes; DST_IMG_WIDTH must be divisible by it.
- UPSP_WRTDATA_WIDTH, 24, pixel width per lane write.
- AXISOUT_DATA_WIDTH, 24, output stream data width; must equal UPSP_WRTDATA_WIDTH.
- DST_IMG_WIDTH, 3840, destination pixels per row.
- DST_IMG_HEIGHT, 2160, destination rows per frame.
- OUT_FIFO_DEPTH, 8, entries per lane FIFO; power of two, at least 2.
- CRF_DATA_WIDTH, 32, width of status/counter outputs.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- crf_ac_UPSTART  in  1  one-cycle frame start pulse
- crf_ac_abort  in  1  synchronous frame abort
- upsp_ac_wvalid  in  N_PARALLEL  per-lane pixel valid
- upsp_ac_wdata  in  N_PARALLEL*UPSP_WRTDATA_WIDTH  per-lane pixel; lane i occupies bits [i*W +: W]
- ac_upsp_wready  out  N_PARALLEL  per-lane ready
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  AXISOUT_DATA_WIDTH  output pixel
- m_axis_tlast  out  1  last pixel of a row
- m_axis_user  out  1  first pixel of a frame
- ac_crf_processing  out  1  high while in RUN
- ac_crf_frame_done  out  1  one-cycle pulse after the last beat of a frame
- ac_crf_OUTHSKCNT  out  CRF_DATA_WIDTH  output handshake count (optional feature)

Behaviour:
- Reset: all FIFOs empty, counters 0, state IDLE. All outputs 0, including ac_upsp_wready and m_axis_tdata.
- Definitions:
  - STRIP_W = DST_IMG_WIDTH / N_PARALLEL.
  - Lane i owns columns [i*STRIP_W, (i+1)*STRIP_W).
  - Counters: col (0..STRIP_W-1), lane (0..N_PARALLEL-1), row (0..DST_IMG_HEIGHT-1). Each is $clog2-sized, minimum 1 bit.
- States:
  - IDLE: ac_upsp_wready = 0, m_axis_tvalid = 0. crf_ac_UPSTART moves to RUN and clears col, lane and row.
  - RUN:
    - ac_upsp_wready[i] = !full[i], registered-free, depending only on lane i FIFO occupancy.
    - A push into a full FIFO is impossible, even if a pop happens in the same cycle (no bypass).
    - m_axis_tvalid = !empty[lane]; tdata = head of FIFO[lane].
    - Beat is accepted when tvalid && tready: pop FIFO[lane], then col++.
    - When col wraps: lane++. When lane wraps: row++.
  - DONE: entered on the beat with col = STRIP_W-1, lane = N_PARALLEL-1, row = DST_IMG_HEIGHT-1. Asserts ac_crf_frame_done for exactly one cycle, then goes to IDLE.
- Output flags:
  - m_axis_tlast = (col == STRIP_W-1) && (lane == N_PARALLEL-1).
  - m_axis_user = (col == 0) && (lane == 0) && (row == 0).
  - Both are valid only while tvalid is high.
- Latency: a pixel pushed into an empty FIFO at cycle t appears on m_axis_tvalid at t+1. Not fall-through from the write port.
- Stability: tdata, tlast and user are held stable while tvalid && !tready. tvalid never drops without a handshake.
- Simultaneous push and pop on the same lane: occupancy is unchanged and data order is preserved.
- crf_ac_UPSTART while in RUN or DONE: ignored.
- crf_ac_abort: takes priority over everything in any state. Next cycle: FIFOs flushed, counters cleared, state IDLE, no frame_done pulse.
- Asynchronous reset mid-frame: immediate return to the reset values.
- ac_crf_processing = (state == RUN).

Optional Feature:
- Macro AC_OUT_HSKCNT_EN.
- Defined:
  - ac_crf_OUTHSKCNT increments on every output handshake and wraps at 2^CRF_DATA_WIDTH.
  - Cleared by reset, crf_ac_UPSTART accepted in IDLE, or abort.
  - Holds its value in IDLE and DONE.
- Undefined: ac_crf_OUTHSKCNT is tied to 0 and no counter logic is present.

Test Plan:
Bench parameters: N_PARALLEL=2, DST_IMG_WIDTH=8, DST_IMG_HEIGHT=2, OUT_FIFO_DEPTH=4.
- Raster order: start; lane0 writes 0x10..0x17, lane1 writes 0x20..0x27, one pixel per cycle per lane; tready=1 -> output 10,11,12,13,20,21,22,23,14,...,27. user=1 only on 0x10; tlast on 0x23 and 0x27; frame_done one cycle after 0x27; 16 beats total.
- Backpressure: tready=0 while lane0 writes 5 pixels -> wready[0] drops after the 4th push. tvalid stays high with tdata=0x10 unchanged; the 5th pixel is accepted once tready returns.
- Lane starvation: lane1 idle, lane0 full -> after 4 lane0 beats, tvalid=0 until lane1's first push. Appears next cycle with data 0x20.
- Abort: abort after 6 beats -> next cycle processing=0, FIFOs empty, no frame_done. A new start then produces user=1 on the first beat.
- Reset mid-frame: rst_n low after 3 beats -> all outputs 0 immediately; state IDLE after release. With AC_OUT_HSKCNT_EN, OUTHSKCNT=0.
- Counter (AC_OUT_HSKCNT_EN): after the full frame, OUTHSKCNT=16 and holds; the next start clears it to 0.
